// File: rtl/pico_pkg.sv
// picoMips controller package: opcodes, sequencer states and instruction field positions.
package pico_pkg;

    typedef enum logic [3:0] {
        OpNop    = 4'h0,
        OpLdi    = 4'h1,
        OpLds    = 4'h2,
        OpLdr    = 4'h3,
        OpAddi   = 4'h4,
        OpAddr   = 4'h5,
        OpMuli   = 4'h6,
        OpStr    = 4'h7,
        OpJmp    = 4'h8,
        OpBz     = 4'h9,
        OpBneg   = 4'hA,
        OpWaitgo = 4'hB,
        OpRsvC   = 4'hC,
        OpRsvD   = 4'hD,
        OpRsvE   = 4'hE,
        OpHalt   = 4'hF
    } opcode_t;

    typedef logic [2:0] state_t;

    localparam state_t StBoot   = 3'd0;
    localparam state_t StRun    = 3'd1;
    localparam state_t StWaitHi = 3'd2;
    localparam state_t StWaitLo = 3'd3;
    localparam state_t StHalt   = 3'd4;

    // Instruction word layout: [15:12] opcode, [11:8] register, [7:0] immediate
    localparam int unsigned OpcHi = 15;
    localparam int unsigned OpcLo = 12;
    localparam int unsigned RegHi = 11;
    localparam int unsigned RegLo = 8;
    localparam int unsigned ImmHi = 7;
    localparam int unsigned ImmLo = 0;

endpackage

// File: rtl/pico_ctrl_if.sv
// Instruction/ALU bus between the picoMips sequencer and the ROM + accumulator ALU.
//   master : controller side (drives PC, pass-through fields and ALU strobes)
//   slave  : ROM/ALU side (drives Instr and ACC)
interface pico_ctrl_if #(
    parameter int unsigned PC_W = 5
);
    logic [15:0]     Instr;
    logic [7:0]      ACC;
    logic [PC_W-1:0] PC;
    logic [7:0]      Imm;
    logic [3:0]      RegAddr;
    logic            RegWE;
    logic            WE;
    logic            SelImm;
    logic            SelSW;
    logic            SelRegData;
    logic            UseACC;

    modport master (
        input  Instr, ACC,
        output PC, Imm, RegAddr, RegWE, WE, SelImm, SelSW, SelRegData, UseACC
    );

    modport slave (
        output Instr, ACC,
        input  PC, Imm, RegAddr, RegWE, WE, SelImm, SelSW, SelRegData, UseACC
    );
endinterface

// File: rtl/pico_ctrl_go_sync.sv
// go_sync: two-flop synchroniser for the asynchronous Go switch.
//   Clock    in  system clock
//   nReset   in  async active-low reset, clears both flops to 0
//   go_async in  raw switch input
//   go_s     out synchronised level
module pico_ctrl_go_sync (
    input  logic Clock,
    input  logic nReset,
    input  logic go_async,
    output logic go_s
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= go_async;
            sync_q <= meta_q;
        end
    end

    assign go_s = sync_q;
endmodule

// File: rtl/pico_ctrl.sv
// picoMips instruction sequencer and decoder.
//   Clock   in  system clock, rising edge
//   nReset  in  async active-low reset
//   bus     master side of pico_ctrl_if: Instr/ACC in; PC, Imm, RegAddr and ALU strobes out
//   Go      in  asynchronous handshake switch (WAITGO)
//   Halted  out high while in HALT
//   IRet    out retired-instruction counter (wraps)
module pico_ctrl
    import pico_pkg::*;
#(
    parameter int unsigned PC_W   = 5,
    parameter int unsigned IRET_W = 16
) (
    input  logic              Clock,
    input  logic              nReset,
    pico_ctrl_if.master       bus,
    input  logic              Go,
    output logic              Halted,
    output logic [IRET_W-1:0] IRet
);
    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [IRET_W-1:0] iret_q;
    logic              retire;
    logic              go_s;
    opcode_t           opc;
    logic [PC_W-1:0]   jump_tgt;

    logic reg_we, we, sel_imm, sel_sw, sel_reg, use_acc;

    pico_ctrl_go_sync u_go_sync (
        .Clock    (Clock),
        .nReset   (nReset),
        .go_async (Go),
        .go_s     (go_s)
    );

    assign opc      = opcode_t'(bus.Instr[OpcHi:OpcLo]);
    assign jump_tgt = bus.Instr[PC_W-1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        retire  = 1'b0;
        reg_we  = 1'b0;
        we      = 1'b0;
        sel_imm = 1'b0;
        sel_sw  = 1'b0;
        sel_reg = 1'b0;
        use_acc = 1'b0;

        case (state_q)
            StBoot: state_d = StRun;

            StRun: begin
                pc_d   = pc_q + PC_W'(1);
                retire = 1'b1;
                unique case (opc)
                    OpNop, OpRsvC, OpRsvD, OpRsvE: ;
                    OpLdi:  begin sel_imm = 1'b1; we = 1'b1; end
                    OpLds:  begin sel_sw  = 1'b1; we = 1'b1; end
                    OpLdr:  begin sel_reg = 1'b1; we = 1'b1; end
                    OpAddi: begin sel_imm = 1'b1; use_acc = 1'b1; we = 1'b1; end
                    OpAddr: begin sel_reg = 1'b1; use_acc = 1'b1; we = 1'b1; end
                    // Multiplier operand is the immediate itself; no mux select
                    OpMuli: begin use_acc = 1'b1; we = 1'b1; end
                    OpStr:  reg_we = 1'b1;
                    OpJmp:  pc_d = jump_tgt;
                    // ACC is already the previous instruction's result
                    OpBz:   if (bus.ACC == 8'd0) pc_d = jump_tgt;
                    OpBneg: if (bus.ACC[7]) pc_d = jump_tgt;
                    OpWaitgo: begin
                        pc_d    = pc_q;
                        retire  = 1'b0;
                        state_d = StWaitHi;
                    end
                    OpHalt: begin
                        pc_d    = pc_q;
                        retire  = 1'b0;
                        state_d = StHalt;
                    end
                endcase
            end

            StWaitHi: if (go_s) state_d = StWaitLo;

            // WAITGO retires only once the switch has been released
            StWaitLo: begin
                if (!go_s) begin
                    pc_d    = pc_q + PC_W'(1);
                    retire  = 1'b1;
                    state_d = StRun;
                end
            end

            StHalt: ;

            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= StBoot;
            pc_q    <= '0;
            iret_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (retire) iret_q <= iret_q + IRET_W'(1);
        end
    end

    assign bus.PC         = pc_q;
    assign bus.Imm        = bus.Instr[ImmHi:ImmLo];
    assign bus.RegAddr    = bus.Instr[RegHi:RegLo];
    assign bus.RegWE      = reg_we;
    assign bus.WE         = we;
    assign bus.SelImm     = sel_imm;
    assign bus.SelSW      = sel_sw;
    assign bus.SelRegData = sel_reg;
    assign bus.UseACC     = use_acc;
    assign Halted         = (state_q == StHalt);
    assign IRet           = iret_q;
endmodule

// File: tb/tb_pico_ctrl.sv
module tb_pico_ctrl;
    // Strobe vector order: {RegWE, WE, SelImm, SelSW, SelRegData, UseACC}
    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_LDI  = 6'b011000;
    localparam logic [5:0] S_LDS  = 6'b010100;
    localparam logic [5:0] S_LDR  = 6'b010010;
    localparam logic [5:0] S_ADDI = 6'b011001;
    localparam logic [5:0] S_ADDR = 6'b010011;
    localparam logic [5:0] S_MULI = 6'b010001;
    localparam logic [5:0] S_STR  = 6'b100000;

    typedef struct {
        int          id;
        logic [15:0] ins;
        logic [5:0]  strb;
        int          pc;
        int          iret;
        logic        halt;
    } exp_t;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        Go;
    logic        Halted;
    logic [15:0] IRet;

    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_step = 0;
    exp_t sb[$];

    pico_ctrl_if #(.PC_W(5)) bus ();

    pico_ctrl #(
        .PC_W   (5),
        .IRET_W (16)
    ) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus),
        .Go     (Go),
        .Halted (Halted),
        .IRet   (IRet)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {bus.RegWE, bus.WE, bus.SelImm, bus.SelSW, bus.SelRegData, bus.UseACC};
    endfunction

    // Scoreboard consumer: outputs are sampled mid-cycle, away from the rising edge
    always @(negedge Clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("s%0d_strb", e.id), 32'(strobes()), 32'(e.strb));
            chk($sformatf("s%0d_pc", e.id), 32'(bus.PC), 32'(e.pc));
            chk($sformatf("s%0d_iret", e.id), 32'(IRet), 32'(e.iret));
            chk($sformatf("s%0d_halt", e.id), 32'(Halted), 32'(e.halt));
            chk($sformatf("s%0d_imm", e.id), 32'(bus.Imm), 32'(e.ins[7:0]));
            chk($sformatf("s%0d_reg", e.id), 32'(bus.RegAddr), 32'(e.ins[11:8]));
        end
    end

    task automatic push(input logic [15:0] ins, input logic [7:0] acc, input logic go,
                        input logic [5:0] e_strb, input int e_pc, input int e_iret,
                        input logic e_halt);
        exp_t e;
        bus.Instr = ins;
        bus.ACC   = acc;
        Go        = go;
        e.id      = n_step;
        e.ins     = ins;
        e.strb    = e_strb;
        e.pc      = e_pc;
        e.iret    = e_iret;
        e.halt    = e_halt;
        n_step++;
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns at the following posedge+1
    task automatic step(input logic [15:0] ins, input logic [7:0] acc, input logic go,
                        input logic [5:0] e_strb, input int e_pc, input int e_iret,
                        input logic e_halt);
        push(ins, acc, go, e_strb, e_pc, e_iret, e_halt);
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        Go     = 1'b0;
        @(posedge Clock);
        #1;
        nReset = 1'b1;
    endtask

    initial begin
        nReset    = 1'b0;
        Go        = 1'b0;
        bus.Instr = 16'h1055;
        bus.ACC   = 8'h00;
        #2;
        chk("rst_pc", 32'(bus.PC), 32'd0);
        chk("rst_iret", 32'(IRet), 32'd0);
        chk("rst_halt", 32'(Halted), 32'd0);
        chk("rst_strb", 32'(strobes()), 32'(S_NONE));
        @(posedge Clock);
        @(posedge Clock);
        #1;
        nReset = 1'b1;

        // LDI 5, ADDI 3, HALT
        step(16'h1005, 8'h00, 1'b0, S_NONE, 0, 0, 1'b0);   // BOOT
        step(16'h1005, 8'h00, 1'b0, S_LDI,  0, 0, 1'b0);
        step(16'h4003, 8'h05, 1'b0, S_ADDI, 1, 1, 1'b0);
        step(16'hF000, 8'h08, 1'b0, S_NONE, 2, 2, 1'b0);
        step(16'h0000, 8'h08, 1'b0, S_NONE, 2, 2, 1'b1);
        step(16'h1077, 8'h08, 1'b0, S_NONE, 2, 2, 1'b1);   // HALT absorbs

        // Branches, jumps and PC wrap
        do_reset();
        step(16'h0000, 8'h00, 1'b0, S_NONE, 0, 0, 1'b0);   // BOOT
        step(16'h0000, 8'h00, 1'b0, S_NONE, 0, 0, 1'b0);
        step(16'h0000, 8'h00, 1'b0, S_NONE, 1, 1, 1'b0);
        step(16'h0000, 8'h00, 1'b0, S_NONE, 2, 2, 1'b0);
        step(16'h9014, 8'h00, 1'b0, S_NONE, 3, 3, 1'b0);   // BZ taken
        step(16'h8003, 8'h00, 1'b0, S_NONE, 20, 4, 1'b0);  // JMP 3
        step(16'h9014, 8'h01, 1'b0, S_NONE, 3, 5, 1'b0);   // BZ not taken
        step(16'hA007, 8'h80, 1'b0, S_NONE, 4, 6, 1'b0);   // BNEG taken
        step(16'hA007, 8'h7F, 1'b0, S_NONE, 7, 7, 1'b0);   // BNEG not taken
        step(16'h9014, 8'h80, 1'b0, S_NONE, 8, 8, 1'b0);   // BZ not taken on negative
        step(16'h801F, 8'h00, 1'b0, S_NONE, 9, 9, 1'b0);   // JMP 31
        step(16'h0000, 8'h00, 1'b0, S_NONE, 31, 10, 1'b0); // NOP wraps
        step(16'h80FF, 8'h00, 1'b0, S_NONE, 0, 11, 1'b0);  // JMP truncated
        step(16'h0000, 8'h00, 1'b0, S_NONE, 31, 12, 1'b0);

        // Reserved opcodes and the rest of the decode table
        step(16'hC000, 8'h00, 1'b0, S_NONE, 0, 13, 1'b0);
        step(16'hD0AB, 8'h00, 1'b0, S_NONE, 1, 14, 1'b0);
        step(16'hE3C4, 8'h00, 1'b0, S_NONE, 2, 15, 1'b0);
        step(16'h7900, 8'h00, 1'b0, S_STR,  3, 16, 1'b0);
        step(16'h2000, 8'h00, 1'b0, S_LDS,  4, 17, 1'b0);
        step(16'h3400, 8'h00, 1'b0, S_LDR,  5, 18, 1'b0);
        step(16'h5100, 8'h00, 1'b0, S_ADDR, 6, 19, 1'b0);
        step(16'h6010, 8'h00, 1'b0, S_MULI, 7, 20, 1'b0);

        // WAITGO: ten idle cycles, four-cycle press, release
        step(16'hB000, 8'h00, 1'b0, S_NONE, 8, 21, 1'b0);
        for (int i = 0; i < 10; i++) step(16'h1077, 8'h00, 1'b0, S_NONE, 8, 21, 1'b0);
        for (int i = 0; i < 4; i++)  step(16'h1077, 8'h00, 1'b1, S_NONE, 8, 21, 1'b0);
        for (int i = 0; i < 3; i++)  step(16'h1077, 8'h00, 1'b0, S_NONE, 8, 21, 1'b0);
        step(16'h1077, 8'h00, 1'b0, S_LDI, 9, 22, 1'b0);   // resumes on third edge

        // Reset asserted while stalled in WAIT_LO
        step(16'hB000, 8'h00, 1'b0, S_NONE, 10, 23, 1'b0);
        for (int i = 0; i < 3; i++) step(16'h1055, 8'h00, 1'b1, S_NONE, 10, 23, 1'b0);
        push(16'h1055, 8'h00, 1'b1, S_NONE, 10, 23, 1'b0);
        @(negedge Clock);
        #2;
        nReset = 1'b0;
        #1;
        chk("arst_pc", 32'(bus.PC), 32'd0);
        chk("arst_iret", 32'(IRet), 32'd0);
        chk("arst_strb", 32'(strobes()), 32'(S_NONE));
        chk("arst_halt", 32'(Halted), 32'd0);
        Go = 1'b0;
        @(posedge Clock);
        #1;
        nReset = 1'b1;
        step(16'h1055, 8'h00, 1'b0, S_NONE, 0, 0, 1'b0);   // BOOT
        step(16'h1055, 8'h00, 1'b0, S_LDI,  0, 0, 1'b0);
        step(16'h0000, 8'h00, 1'b0, S_NONE, 1, 1, 1'b0);

        @(negedge Clock);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
